ysyx_220053_trap_seq: RTL and testbench
=======================================

// Module: ysyx_220053_trap_seq
// PURPOSE
//   Trap sequencer for the machine-mode CSR file. Takes ecall/mret/timer-interrupt events at the
//   commit boundary and drives the single CSR write port over several cycles (mepc, mcause,
//   mstatus), then issues a one-cycle PC redirect. Instruction-side CSR writes share the same
//   port and pass through only while the sequencer is idle. Sits between WB/commit and the CSR file.
// PARAMETERS
//   XLEN       64                    datapath / CSR width
//   CAUSE_ECL  64'hb                 mcause value for ecall from M-mode
//   CAUSE_MTI  64'h8000000000000007  mcause value for machine timer interrupt
// PORTS
//   clk               in   1     clock, all state on posedge
//   rst               in   1     asynchronous, active-high reset
//   commit_valid_i    in   1     an instruction commits this cycle
//   commit_pc_i       in   XLEN  PC of committing instruction
//   next_pc_i         in   XLEN  PC following committing instruction
//   ecall_i / mret_i  in   1     committing instruction is ecall / mret (qualified by commit_valid_i)
//   mtip_i            in   1     machine timer interrupt pending (level)
//   mstatus_i, mtvec_i, mepc_i  in XLEN  current CSR values
//   inst_csr_wen_i    in   1     instruction-side CSR write request
//   inst_csr_id_i     in   12    its CSR address
//   inst_csr_wdata_i  in   XLEN  its write data (already op-merged)
//   inst_csr_ready_o  out  1     instruction write accepted this cycle
//   csr_wen_o / csr_id_o[11:0] / csr_wdata_o[XLEN]  out  muxed CSR write port
//   stall_o           out  1     hold fetch..commit; high whenever state != IDLE
//   redirect_o        out  1     one-cycle PC redirect pulse
//   redirect_pc_o     out  XLEN  target PC, valid with redirect_o
// BEHAVIOUR
//   - Reset (async): state=IDLE, epc/cause latches=0; all outputs 0 while rst is high. Reset mid-
//     sequence aborts it, no further CSR writes, no redirect.
//   - States: IDLE, W_EPC, W_CAUSE, W_STAT, M_STAT, REDIR.
//   - Accept only in IDLE with commit_valid_i=1. Priority: irq (mtip_i & mstatus_i[3]) > ecall > mret.
//     irq: epc<=next_pc_i, cause<=CAUSE_MTI (committing instr completes). ecall: epc<=commit_pc_i,
//     cause<=CAUSE_ECL. Trap: IDLE->W_EPC->W_CAUSE->W_STAT->REDIR->IDLE. mret: IDLE->M_STAT->REDIR->IDLE.
//   - W_EPC: csr_wen_o=1, id 12'h341, data=epc. W_CAUSE: id 12'h342, data=cause.
//   - W_STAT: id 12'h300, data=mstatus_i with [7]=mstatus_i[3], [3]=0, [12:11]=2'b11.
//   - M_STAT: id 12'h300, data=mstatus_i with [3]=mstatus_i[7], [7]=1, [12:11]=2'b11.
//   - REDIR: redirect_o=1; pc={mtvec_i[XLEN-1:2],2'b00} for trap, mepc_i for mret. No CSR write.
//   - Latency: accept at edge N -> redirect_o high in cycle N+4 (trap), N+2 (mret).
//   - IDLE: csr_* = inst_csr_*_i pass-through, inst_csr_ready_o=1, even in accept cycle (that write
//     commits first; W_STAT then reads the updated mstatus_i). Non-IDLE: ready=0, inst writes dropped
//     (requester is stalled). csr_wen_o=0 when no writer.
//   - mtip_i / ecall_i / mret_i ignored while busy; re-evaluated in IDLE. No re-entry after trap since MIE=0.
//   - commit_valid_i=0: no events taken regardless of mtip_i.
// TESTING
//   1. ecall at commit_pc=0x80000010, mtvec=0x80000100 -> writes 341<=0x80000010, 342<=0xb, 300 MIE=0
//      MPIE=old MIE, then redirect to 0x80000100 four cycles after accept; stall_o high 4 cycles.
//   2. mret, mepc=0x80000014, mstatus=0x80 -> one write 300<=0x1888, redirect 0x80000014 at N+2.
//   3. mtip=1, MIE=1, commit with next_pc=0x80000024 and ecall=1 -> irq wins: mepc=0x80000024,
//      mcause=0x8000000000000007; MIE=0 -> no retake.
//   4. mtip=1, MIE=0 or commit_valid=0 -> no trap; inst CSR write 340<=0x55 passes through, ready=1.
//   5. inst write during W_CAUSE -> ready=0, port shows 342 write only; rst asserted in W_CAUSE ->
//      outputs 0 immediately, no W_STAT write, no redirect.
//   6. mtvec=0x80000103 -> redirect_pc=0x80000100.

Source files
------------

// File: rtl/ysyx_220053_trap_seq.sv
// Trap sequencer for the machine-mode CSR file.
// Turns ecall / mret / timer-interrupt events seen at commit into a short
// series of writes on the single CSR write port, followed by a one-cycle
// PC redirect. Instruction-side CSR writes use the same port while idle.
//
// Handshake: inst_csr_ready_o is high exactly when the sequencer is idle.
// An instruction write is taken in any cycle where inst_csr_wen_i and
// inst_csr_ready_o are both high. While busy, the requester is held by
// stall_o and any write presented is dropped.
module ysyx_220053_trap_seq #(
  parameter int unsigned     XLEN      = 64,
  parameter logic [XLEN-1:0] CAUSE_ECL = 64'hb,
  parameter logic [XLEN-1:0] CAUSE_MTI = 64'h8000000000000007
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            commit_valid_i,
  input  logic [XLEN-1:0] commit_pc_i,
  input  logic [XLEN-1:0] next_pc_i,
  input  logic            ecall_i,
  input  logic            mret_i,
  input  logic            mtip_i,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic            inst_csr_wen_i,
  input  logic [11:0]     inst_csr_id_i,
  input  logic [XLEN-1:0] inst_csr_wdata_i,
  output logic            inst_csr_ready_o,
  output logic            csr_wen_o,
  output logic [11:0]     csr_id_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            stall_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_EPC   = 3'd1,
    W_CAUSE = 3'd2,
    W_STAT  = 3'd3,
    M_STAT  = 3'd4,
    REDIR   = 3'd5
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] epc, cause;
  logic            is_trap;
  logic            take_irq, take_ecall, take_mret;
  logic [XLEN-1:0] stat_trap, stat_mret;

  // Event priority: interrupt, then ecall, then mret.
  assign take_irq   = commit_valid_i & mtip_i & mstatus_i[3];
  assign take_ecall = commit_valid_i & ecall_i & ~take_irq;
  assign take_mret  = commit_valid_i & mret_i & ~take_irq & ~ecall_i;

  assign dbg_state = state;

  // New mstatus values: trap stacks MIE into MPIE, mret restores it.
  always_comb begin
    stat_trap        = mstatus_i;
    stat_trap[7]     = mstatus_i[3];
    stat_trap[3]     = 1'b0;
    stat_trap[12:11] = 2'b11;
    stat_mret        = mstatus_i;
    stat_mret[3]     = mstatus_i[7];
    stat_mret[7]     = 1'b1;
    stat_mret[12:11] = 2'b11;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Capture epc/cause and the trap-vs-mret flag at accept time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc     <= '0;
      cause   <= '0;
      is_trap <= 1'b0;
    end else if (state == IDLE) begin
      if (take_irq) begin
        epc     <= next_pc_i;   // interrupted instruction still completes
        cause   <= CAUSE_MTI;
        is_trap <= 1'b1;
      end else if (take_ecall) begin
        epc     <= commit_pc_i;
        cause   <= CAUSE_ECL;
        is_trap <= 1'b1;
      end else if (take_mret) begin
        is_trap <= 1'b0;
      end
    end
  end

  // Next state and muxed CSR port / redirect outputs.
  always_comb begin
    state_nxt        = state;
    csr_wen_o        = 1'b0;
    csr_id_o         = 12'h000;
    csr_wdata_o      = '0;
    inst_csr_ready_o = 1'b0;
    stall_o          = 1'b1;
    redirect_o       = 1'b0;
    redirect_pc_o    = '0;
    case (state)
      IDLE: begin
        stall_o          = 1'b0;
        inst_csr_ready_o = 1'b1;
        csr_wen_o        = inst_csr_wen_i;
        csr_id_o         = inst_csr_id_i;
        csr_wdata_o      = inst_csr_wdata_i;
        if (take_irq || take_ecall) state_nxt = W_EPC;
        else if (take_mret)         state_nxt = M_STAT;
      end
      W_EPC: begin
        csr_wen_o   = 1'b1;
        csr_id_o    = 12'h341;
        csr_wdata_o = epc;
        state_nxt   = W_CAUSE;
      end
      W_CAUSE: begin
        csr_wen_o   = 1'b1;
        csr_id_o    = 12'h342;
        csr_wdata_o = cause;
        state_nxt   = W_STAT;
      end
      W_STAT: begin
        csr_wen_o   = 1'b1;
        csr_id_o    = 12'h300;
        csr_wdata_o = stat_trap;
        state_nxt   = REDIR;
      end
      M_STAT: begin
        csr_wen_o   = 1'b1;
        csr_id_o    = 12'h300;
        csr_wdata_o = stat_mret;
        state_nxt   = REDIR;
      end
      REDIR: begin
        redirect_o    = 1'b1;
        redirect_pc_o = is_trap ? (mtvec_i & ~{{(XLEN-2){1'b0}}, 2'b11}) : mepc_i;
        state_nxt     = IDLE;
      end
      default: begin
        stall_o   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
    // Every output is quiet while reset is held.
    if (rst) begin
      csr_wen_o        = 1'b0;
      csr_id_o         = 12'h000;
      csr_wdata_o      = '0;
      inst_csr_ready_o = 1'b0;
      stall_o          = 1'b0;
      redirect_o       = 1'b0;
      redirect_pc_o    = '0;
    end
  end

endmodule

// File: tb/tb_ysyx_220053_trap_seq.sv
// Bench for ysyx_220053_trap_seq: vector table, directed corner sequences
// and a randomized run against a cycle-list reference model.
module tb_ysyx_220053_trap_seq;

  localparam logic [63:0] CAUSE_ECL = 64'hb;
  localparam logic [63:0] CAUSE_MTI = 64'h8000000000000007;
  localparam logic [63:0] CPC   = 64'h80000010;
  localparam logic [63:0] NPC   = 64'h80000024;
  localparam logic [63:0] MTVEC = 64'h80000100;
  localparam logic [63:0] MEPC  = 64'h80000014;

  typedef struct packed {
    logic        wen;
    logic [11:0] id;
    logic [63:0] data;
    logic        ready;
    logic        stall;
    logic        redir;
    logic [63:0] rpc;
  } rec_t;
  localparam int REC_W = $bits(rec_t);

  typedef struct {
    logic        cv, ec, mr, mt;
    logic [63:0] mst;
    logic        iw;
    logic [11:0] iid;
    logic [63:0] idata;
    rec_t        e0;
    rec_t        e1;
  } vec_t;

  logic        clk, rst;
  logic        commit_valid, ecall, mret, mtip;
  logic [63:0] commit_pc, next_pc, mstatus, mtvec, mepc;
  logic        inst_wen;
  logic [11:0] inst_id;
  logic [63:0] inst_wdata;
  logic        inst_ready, csr_wen, stall, redirect;
  logic [11:0] csr_id;
  logic [63:0] csr_wdata, redirect_pc;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [REC_W-1:0] exp_q[$];
  vec_t vecs[8];

  ysyx_220053_trap_seq dut (
    .clk(clk), .rst(rst),
    .commit_valid_i(commit_valid), .commit_pc_i(commit_pc), .next_pc_i(next_pc),
    .ecall_i(ecall), .mret_i(mret), .mtip_i(mtip),
    .mstatus_i(mstatus), .mtvec_i(mtvec), .mepc_i(mepc),
    .inst_csr_wen_i(inst_wen), .inst_csr_id_i(inst_id), .inst_csr_wdata_i(inst_wdata),
    .inst_csr_ready_o(inst_ready),
    .csr_wen_o(csr_wen), .csr_id_o(csr_id), .csr_wdata_o(csr_wdata),
    .stall_o(stall), .redirect_o(redirect), .redirect_pc_o(redirect_pc),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model helpers ----------------
  function automatic rec_t mk(input logic w, input logic [11:0] i, input logic [63:0] d,
                              input logic rdy, input logic st, input logic rd,
                              input logic [63:0] pc);
    rec_t r;
    r.wen = w; r.id = i; r.data = d; r.ready = rdy; r.stall = st; r.redir = rd; r.rpc = pc;
    return r;
  endfunction

  // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
  function automatic logic [63:0] trap_stat(input logic [63:0] m);
    return (m & ~64'h1888) | 64'h1800 | ({63'd0, m[3]} << 7);
  endfunction

  // mret: MIE <- MPIE, MPIE <- 1, MPP field written as M.
  function automatic logic [63:0] mret_stat(input logic [63:0] m);
    return (m & ~64'h1888) | 64'h1880 | ({63'd0, m[7]} << 3);
  endfunction

  function automatic rec_t idle_rec(input logic w, input logic [11:0] i, input logic [63:0] d);
    return w ? mk(1'b1, i, d, 1'b1, 1'b0, 1'b0, 64'd0) : mk(1'b0, 12'h0, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0);
  endfunction

  // Queue the cycles that follow an accepted event, from the current inputs.
  task automatic model_accept();
    logic [63:0] e;
    logic [63:0] c;
    if (commit_valid && (mtip && mstatus[3] || ecall)) begin
      e = (mtip && mstatus[3]) ? next_pc : commit_pc;
      c = (mtip && mstatus[3]) ? CAUSE_MTI : CAUSE_ECL;
      exp_q.push_back(mk(1'b1, 12'h341, e, 1'b0, 1'b1, 1'b0, 64'd0));
      exp_q.push_back(mk(1'b1, 12'h342, c, 1'b0, 1'b1, 1'b0, 64'd0));
      exp_q.push_back(mk(1'b1, 12'h300, trap_stat(mstatus), 1'b0, 1'b1, 1'b0, 64'd0));
      exp_q.push_back(mk(1'b0, 12'h0, 64'd0, 1'b0, 1'b1, 1'b1, {mtvec[63:2], 2'b00}));
    end else if (commit_valid && mret) begin
      exp_q.push_back(mk(1'b1, 12'h300, mret_stat(mstatus), 1'b0, 1'b1, 1'b0, 64'd0));
      exp_q.push_back(mk(1'b0, 12'h0, 64'd0, 1'b0, 1'b1, 1'b1, mepc));
    end
  endtask

  // ---------------- checking ----------------
  task automatic cmp(input string name, input rec_t e);
    rec_t a;
    a.wen = csr_wen; a.id = csr_id; a.data = csr_wdata; a.ready = inst_ready;
    a.stall = stall; a.redir = redirect; a.rpc = redirect_pc;
    if (!e.wen) begin a.id = 12'h0; a.data = 64'd0; end
    if (!e.redir) a.rpc = 64'd0;
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t got wen=%b id=%h data=%h rdy=%b stall=%b redir=%b pc=%h want wen=%b id=%h data=%h rdy=%b stall=%b redir=%b pc=%h",
               name, $time, a.wen, a.id, a.data, a.ready, a.stall, a.redir, a.rpc,
               e.wen, e.id, e.data, e.ready, e.stall, e.redir, e.rpc);
    end
  endtask

  // Inputs are set just after a posedge; outputs are sampled at the negedge.
  task automatic check_cycle(input string name, input rec_t e);
    @(negedge clk);
    cmp(name, e);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    commit_valid = 1'b0; ecall = 1'b0; mret = 1'b0; mtip = 1'b0;
    inst_wen = 1'b0; inst_id = 12'h0; inst_wdata = 64'd0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic vec_t mkv(input logic cv, ec, mr, mt, input logic [63:0] mst,
                               input logic iw, input logic [11:0] iid, input logic [63:0] idata,
                               input rec_t e0, input rec_t e1);
    vec_t v;
    v.cv = cv; v.ec = ec; v.mr = mr; v.mt = mt; v.mst = mst;
    v.iw = iw; v.iid = iid; v.idata = idata; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    rec_t idle0, zero_rec;
    idle0    = mk(1'b0, 12'h0, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0);
    zero_rec = mk(1'b0, 12'h0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0);

    // Accept-cycle port view and first post-accept cycle, one row per case.
    vecs[0] = mkv(0,0,0,1, 64'h8,  1, 12'h340, 64'h55, mk(1,12'h340,64'h55,1,0,0,0), idle0);
    vecs[1] = mkv(1,0,0,1, 64'h0,  1, 12'h340, 64'h55, mk(1,12'h340,64'h55,1,0,0,0), idle0);
    vecs[2] = mkv(1,1,0,0, 64'h8,  0, 12'h0, 64'd0, idle0, mk(1,12'h341,CPC,0,1,0,0));
    vecs[3] = mkv(1,0,1,0, 64'h80, 0, 12'h0, 64'd0, idle0, mk(1,12'h300,64'h1888,0,1,0,0));
    vecs[4] = mkv(1,1,0,1, 64'h8,  0, 12'h0, 64'd0, idle0, mk(1,12'h341,NPC,0,1,0,0));
    vecs[5] = mkv(1,1,1,1, 64'h0,  0, 12'h0, 64'd0, idle0, mk(1,12'h341,CPC,0,1,0,0));
    vecs[6] = mkv(1,0,1,1, 64'h88, 0, 12'h0, 64'd0, idle0, mk(1,12'h341,NPC,0,1,0,0));
    vecs[7] = mkv(0,1,1,1, 64'h8,  1, 12'h300, 64'h1, mk(1,12'h300,64'h1,1,0,0,0), idle0);

    // Reset: outputs must be quiet even with an instruction write pending.
    rst = 1'b1;
    clear_events();
    commit_pc = CPC; next_pc = NPC; mstatus = 64'h8; mtvec = MTVEC; mepc = MEPC;
    inst_wen = 1'b1; inst_id = 12'h340; inst_wdata = 64'h55;
    #2;
    cmp("reset_quiet", zero_rec);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_events();

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      apply_reset();
      commit_valid = vecs[i].cv; ecall = vecs[i].ec; mret = vecs[i].mr; mtip = vecs[i].mt;
      mstatus = vecs[i].mst;
      inst_wen = vecs[i].iw; inst_id = vecs[i].iid; inst_wdata = vecs[i].idata;
      check_cycle($sformatf("vec%0d_accept", i), vecs[i].e0);
      clear_events();
      check_cycle($sformatf("vec%0d_next", i), vecs[i].e1);
    end

    // ecall full sequence, MIE was 1.
    apply_reset();
    mstatus = 64'h8; mtvec = MTVEC; commit_valid = 1'b1; ecall = 1'b1;
    check_cycle("ecall_accept", idle0);
    clear_events();
    check_cycle("ecall_epc",   mk(1,12'h341,CPC,0,1,0,0));
    check_cycle("ecall_cause", mk(1,12'h342,CAUSE_ECL,0,1,0,0));
    check_cycle("ecall_stat",  mk(1,12'h300,64'h1880,0,1,0,0));
    check_cycle("ecall_redir", mk(0,12'h0,64'd0,0,1,1,MTVEC));
    check_cycle("ecall_done",  idle0);

    // mret full sequence.
    mstatus = 64'h80; mepc = MEPC; commit_valid = 1'b1; mret = 1'b1;
    check_cycle("mret_accept", idle0);
    clear_events();
    check_cycle("mret_stat",  mk(1,12'h300,64'h1888,0,1,0,0));
    check_cycle("mret_redir", mk(0,12'h0,64'd0,0,1,1,MEPC));
    check_cycle("mret_done",  idle0);

    // Interrupt beats a simultaneous ecall; afterwards MIE=0 prevents retake.
    mstatus = 64'h8; mtvec = 64'h80000103; commit_valid = 1'b1; ecall = 1'b1; mtip = 1'b1;
    check_cycle("irq_accept", idle0);
    ecall = 1'b0; commit_valid = 1'b0;
    check_cycle("irq_epc",   mk(1,12'h341,NPC,0,1,0,0));
    check_cycle("irq_cause", mk(1,12'h342,CAUSE_MTI,0,1,0,0));
    check_cycle("irq_stat",  mk(1,12'h300,64'h1880,0,1,0,0));
    check_cycle("irq_redir_align", mk(0,12'h0,64'd0,0,1,1,64'h80000100));
    mstatus = 64'h1880; commit_valid = 1'b1;
    check_cycle("irq_no_retake0", idle0);
    check_cycle("irq_no_retake1", idle0);
    clear_events();

    // Busy write dropped in W_CAUSE, then reset aborts the sequence.
    mstatus = 64'h8; mtvec = MTVEC; commit_valid = 1'b1; ecall = 1'b1;
    check_cycle("abort_accept", idle0);
    clear_events();
    check_cycle("abort_epc", mk(1,12'h341,CPC,0,1,0,0));
    inst_wen = 1'b1; inst_id = 12'h305; inst_wdata = 64'h77;
    #2;
    cmp("busy_drop", mk(1,12'h342,CAUSE_ECL,0,1,0,0));
    rst = 1'b1;
    #1;
    cmp("abort_quiet", zero_rec);
    @(posedge clk);
    #1;
    cmp("abort_held", zero_rec);
    rst = 1'b0;
    clear_events();
    for (int k = 0; k < 4; k++) check_cycle($sformatf("abort_idle%0d", k), idle0);

    // Randomized run against the cycle-list model.
    for (int n = 0; n < 600; n++) begin
      rec_t e;
      inst_wen   = ($urandom_range(0, 2) == 0);
      inst_id    = 12'($urandom);
      inst_wdata = {$urandom, $urandom};
      ecall  = ($urandom_range(0, 3) == 0);
      mret   = ($urandom_range(0, 3) == 0);
      mtip   = ($urandom_range(0, 3) == 0);
      commit_valid = ($urandom_range(0, 1) == 1);
      if (exp_q.size() == 0) begin
        commit_pc = {$urandom, $urandom};
        next_pc   = {$urandom, $urandom};
        mstatus   = {$urandom, $urandom};
        mtvec     = {$urandom, $urandom};
        mepc      = {$urandom, $urandom};
        e = idle_rec(inst_wen, inst_id, inst_wdata);
        model_accept();
      end else begin
        e = rec_t'(exp_q.pop_front());
      end
      check_cycle("rand", e);
    end
    clear_events();
    while (exp_q.size() > 0) check_cycle("rand_drain", rec_t'(exp_q.pop_front()));
    check_cycle("rand_final_idle", idle0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
